// File: rtl/cordic_cosine_range_reduce.sv
// Full-circle front end for the cosine core: clamps and folds [-pi, pi] into [-pi/2, pi/2],
// runs one core computation and sign-corrects its result. Optional watchdog: CORDIC_RANGE_TIMEOUT_EN.
module cordic_cosine_range_reduce #(
  parameter int BIT_WIDTH      = 16,
  parameter int FRAC_BITS      = 13,
  parameter int PI             = 25736,
  parameter int HALF_PI        = 12868,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [BIT_WIDTH-1:0] angle,
  output logic signed [BIT_WIDTH-1:0] value,
  output logic                        ready,
  output logic                        done,
  output logic                        core_start,
  output logic signed [BIT_WIDTH-1:0] core_angle,
  input  logic signed [BIT_WIDTH-1:0] core_value,
  input  logic                        core_ready,
  input  logic                        core_done,
  output logic                        timeout
);

  if (FRAC_BITS >= BIT_WIDTH || HALF_PI >= PI || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cordic_cosine_range_reduce: inconsistent parameters");
  end

  localparam logic signed [BIT_WIDTH-1:0] PI_S       = BIT_WIDTH'(PI);
  localparam logic signed [BIT_WIDTH-1:0] NEG_PI_S   = BIT_WIDTH'(-PI);
  localparam logic signed [BIT_WIDTH-1:0] HALF_S     = BIT_WIDTH'(HALF_PI);
  localparam logic signed [BIT_WIDTH-1:0] NEG_HALF_S = BIT_WIDTH'(-HALF_PI);
  localparam logic signed [BIT_WIDTH-1:0] MAX_S      = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [BIT_WIDTH-1:0] MIN_S      = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACK, S_WAIT, S_FIX, S_DONE} state_t;

  function automatic logic signed [BIT_WIDTH-1:0] clamp_angle(
    input logic signed [BIT_WIDTH-1:0] a);
    if (a > PI_S)          return PI_S;
    else if (a < NEG_PI_S) return NEG_PI_S;
    else                   return a;
  endfunction

  function automatic logic signed [BIT_WIDTH-1:0] sat_neg(
    input logic signed [BIT_WIDTH-1:0] x);
    if (x == MIN_S) return MAX_S;
    else            return -x;
  endfunction

  state_t                        state_q, state_d;
  logic signed [BIT_WIDTH-1:0]   value_q, core_angle_q, cap_q;
  logic                          neg_q;
  logic signed [BIT_WIDTH-1:0]   clamped, fold_angle;
  logic                          fold_neg, accept, in_watch, tmo_hit, tmo_abort;

  assign ready      = ~reset & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign done       = (state_q == S_DONE);
  assign accept     = start & ready;
  assign core_start = ~reset & (state_q == S_ISSUE) & core_ready;
  assign core_angle = core_angle_q;
  assign value      = value_q;
  assign in_watch   = (state_q == S_ACK) | (state_q == S_WAIT);
  assign tmo_abort  = in_watch & (state_d == S_DONE);

  // Input stage: clamp to [-pi, pi], then mirror the outer quadrants about +/-pi/2
  always_comb begin
    clamped    = clamp_angle(angle);
    fold_angle = clamped;
    fold_neg   = 1'b0;
    if (clamped > HALF_S) begin
      fold_angle = PI_S - clamped;
      fold_neg   = 1'b1;
    end else if (clamped < NEG_HALF_S) begin
      fold_angle = NEG_PI_S - clamped;
      fold_neg   = 1'b1;
    end
  end

  // ACK only moves on once the core shows busy, so a done left over from a prior run is skipped
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_ISSUE;
      S_ISSUE:        if (core_ready) state_d = S_ACK;
      S_ACK: begin
        if (!core_ready || !core_done) state_d = S_WAIT;
        else if (tmo_hit)              state_d = S_DONE;
      end
      S_WAIT: begin
        if (core_done)    state_d = S_FIX;
        else if (tmo_hit) state_d = S_DONE;
      end
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      value_q      <= '0;
      core_angle_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) core_angle_q <= fold_angle;
      if (state_q == S_FIX) value_q <= neg_q ? sat_neg(cap_q) : cap_q;
      else if (tmo_abort)   value_q <= '0;
    end
  end

  // Capture stage: data registers carry no reset
  always_ff @(posedge clk) begin
    if (accept) neg_q <= fold_neg;
    if (state_q == S_WAIT && core_done) cap_q <= core_value;
  end

`ifdef CORDIC_RANGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  assign tmo_hit = in_watch & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= in_watch ? cnt_q + CNT_W'(1) : '0;
      if (accept)         timeout_q <= 1'b0;
      else if (tmo_abort) timeout_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_cosine_range_reduce.sv
// Directed, table-driven bench for cordic_cosine_range_reduce with a behavioural cosine core
// that answers 8 cycles after core_start.
module tb_cordic_cosine_range_reduce;

  logic               clk = 1'b0;
  logic               reset, start;
  logic signed [15:0] angle, value, core_angle;
  logic               ready, done, core_start, timeout;
  logic signed [15:0] core_value_m = 16'sd0;
  logic               core_ready_m = 1'b1;
  logic               core_done_m  = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cordic_cosine_range_reduce dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .angle      (angle),
    .value      (value),
    .ready      (ready),
    .done       (done),
    .core_start (core_start),
    .core_angle (core_angle),
    .core_value (core_value_m),
    .core_ready (core_ready_m),
    .core_done  (core_done_m),
    .timeout    (timeout)
  );

  // Behavioural core; stale_mode delays the busy indication by two cycles after core_start
  int                 cc = 0;
  bit                 act = 1'b0;
  bit                 stale_mode = 1'b0;
  bit                 never_done = 1'b0;
  int                 nstarts = 0;
  logic signed [15:0] seen_angle = 16'sd0;
  logic signed [15:0] resp = 16'sd0;

  always @(posedge clk) begin
    if (core_start) begin
      nstarts    <= nstarts + 1;
      seen_angle <= core_angle;
      cc         <= 1;
      act        <= 1'b1;
      if (!stale_mode) begin
        core_ready_m <= 1'b0;
        core_done_m  <= 1'b0;
      end
    end else if (act) begin
      cc <= cc + 1;
      if (stale_mode && cc == 2) begin
        core_ready_m <= 1'b0;
        core_done_m  <= 1'b0;
      end
      if (cc == 8) begin
        act          <= 1'b0;
        core_ready_m <= 1'b1;
        if (!never_done) begin
          core_done_m  <= 1'b1;
          core_value_m <= resp;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic signed [31:0] act_v,
                     input logic signed [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act_v, exp_v);
    end
  endtask

  // Issues one request and waits (bounded) for done; reports the cycles waited
  task automatic run_req(input string nm, input logic signed [15:0] a,
                         input logic signed [15:0] r, input int budget, output int waited);
    resp = r;
    for (int i = 0; i < 50; i++) begin
      if (ready) break;
      @(negedge clk);
    end
    chk({nm, "_ready"}, ready, 1);
    start = 1'b1;
    angle = a;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_done_drop"}, done, 0);
    waited = 0;
    while (!done && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    chk({nm, "_done"}, done, 1);
  endtask

  typedef struct {
    logic signed [15:0] ang;
    logic signed [15:0] exp_core;
    logic signed [15:0] resp;
    logic signed [15:0] exp_val;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int w, n0;

    vecs[0]  = '{16'sd0,      16'sd0,     16'sd8192,   16'sd8192};
    vecs[1]  = '{16'sd17157,  16'sd8579,  16'sd4096,  -16'sd4096};
    vecs[2]  = '{-16'sd17157, -16'sd8579, 16'sd4096,  -16'sd4096};
    vecs[3]  = '{-16'sd25736, 16'sd0,     16'sd8192,  -16'sd8192};
    vecs[4]  = '{16'sd30000,  16'sd0,     16'sd8192,  -16'sd8192};
    vecs[5]  = '{-16'sd30000, 16'sd0,     16'sd8000,  -16'sd8000};
    vecs[6]  = '{16'sd12868,  16'sd12868, 16'sd5,      16'sd5};
    vecs[7]  = '{-16'sd12868, -16'sd12868, 16'sd7,     16'sd7};
    vecs[8]  = '{16'sd12869,  16'sd12867, 16'sd3,     -16'sd3};
    vecs[9]  = '{16'sd20000,  16'sd5736,  -16'sd32768, 16'sd32767};
    vecs[10] = '{16'sd25736,  16'sd0,     16'sd8192,  -16'sd8192};
    vecs[11] = '{16'sd1000,   16'sd1000,  -16'sd500,  -16'sd500};

    reset = 1'b1;
    start = 1'b0;
    angle = 16'sd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_value", value, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_angle", core_angle, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", ready, 1);

    foreach (vecs[k]) begin
      n0 = nstarts;
      run_req($sformatf("vec%0d", k), vecs[k].ang, vecs[k].resp, 40, w);
      chk($sformatf("vec%0d_core_angle", k), seen_angle, vecs[k].exp_core);
      chk($sformatf("vec%0d_value", k), value, vecs[k].exp_val);
      chk($sformatf("vec%0d_timeout", k), timeout, 0);
      chk($sformatf("vec%0d_nstarts", k), nstarts - n0, 1);
    end

    // start pulsed while waiting on the core is dropped
    n0 = nstarts;
    resp = 16'sd1234;
    start = 1'b1;
    angle = 16'sd0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    angle = 16'sd17157;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!done && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("busy_start_done", done, 1);
    chk("busy_start_value", value, 1234);
    chk("busy_start_angle", seen_angle, 0);
    repeat (3) @(negedge clk);
    chk("busy_start_nstarts", nstarts - n0, 1);

    // core_done still high from the previous run must not be captured
    run_req("stale_prep", 16'sd0, 16'sd1111, 40, w);
    chk("stale_prep_value", value, 1111);
    stale_mode = 1'b1;
    run_req("stale", 16'sd17157, 16'sd2222, 40, w);
    chk("stale_value", value, -2222);
    stale_mode = 1'b0;

    // reset while in WAIT abandons the request
    n0 = nstarts;
    resp = 16'sd3333;
    start = 1'b1;
    angle = 16'sd0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("wait_rst_done", done, 0);
    chk("wait_rst_value", value, 0);
    @(negedge clk);
    chk("wait_rst_ready", ready, 1);
    repeat (15) @(negedge clk);
    chk("wait_rst_done_after", done, 0);
    chk("wait_rst_value_after", value, 0);
    chk("wait_rst_nstarts", nstarts - n0, 1);

    run_req("after_rst", -16'sd17157, 16'sd4096, 40, w);
    chk("after_rst_core_angle", seen_angle, -8579);
    chk("after_rst_value", value, -4096);

`ifdef CORDIC_RANGE_TIMEOUT_EN
    never_done = 1'b1;
    run_req("tmo", 16'sd0, 16'sd8192, 100, w);
    chk("tmo_flag", timeout, 1);
    chk("tmo_value", value, 0);
    chk("tmo_latency", (w >= 62 && w <= 68), 1);
    never_done = 1'b0;
    repeat (10) @(negedge clk);
    run_req("tmo_clear", 16'sd17157, 16'sd4096, 40, w);
    chk("tmo_clear_flag", timeout, 0);
    chk("tmo_clear_value", value, -4096);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
